// File: rtl/uart_tx_feeder_if.sv
// Handshake bundle between a byte producer, the feeder FIFO and a UART byte transmitter.
interface uart_tx_feeder_if #(
    parameter int unsigned ADDR_W = 4
) ();
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            send_en;
    logic            tx_done;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] count;
    logic            busy;
    logic            overflow;
    logic            timeout_err;

    modport master (
        output wr_en, wr_data, send_en, tx_done,
        input  tx_data, tx_start, full, empty, count, busy, overflow, timeout_err
    );

    modport slave (
        input  wr_en, wr_data, send_en, tx_done,
        output tx_data, tx_start, full, empty, count, busy, overflow, timeout_err
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART byte transmitter one byte at a time, with a per-byte
// completion timeout and sticky overflow / timeout error flags.
module uart_tx_feeder #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned TIMEOUT = 131072
) (
    input logic             clk,
    input logic             rst,
    uart_tx_feeder_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

    localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);
    localparam logic [17:0]     TimerLast = 18'(TIMEOUT - 1);

    state_e            state_q;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [7:0]        tx_data_q;
    logic [17:0]       timer_q;
    logic              overflow_q;
    logic              timeout_err_q;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);
    // Pop depends only on registered count, so a byte written this cycle cannot leave yet.
    assign pop   = (state_q == StIdle) && bus.send_en && !empty;
    assign push  = bus.wr_en && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (bus.wr_en && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            tx_data_q     <= 8'h00;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        tx_data_q <= mem[rd_ptr_q];
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    timer_q <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    // Done wins over a coinciding timeout.
                    if (bus.tx_done) begin
                        state_q <= StIdle;
                    end else if (timer_q == TimerLast) begin
                        state_q       <= StIdle;
                        timeout_err_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = (state_q == StStart);
    assign bus.busy        = (state_q != StIdle);
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.timeout_err = timeout_err_q;
endmodule
